// File: rtl/usb_transmitter.sv
// Serial USB low-level transmitter: parallel bytes to an NRZI differential line, LSB first,
// one bit per clock, with an SE0/SE0/J end-of-packet sequence.
module usb_transmitter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_enable,
    input  logic [7:0] data,
    input  logic       eop,
    output logic       d_plus,
    output logic       d_minus,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StEop1,
        StEop2,
        StEopJ
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       level_q, level_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       busy_q, busy_d;

    logic       last_bit;
    logic       load_ok;

    // cnt_q == 7 marks the cycle whose closing edge drives bit 7; a new byte may be taken there.
    assign last_bit = (state_q == StSend) && (cnt_q == 3'd7);
    assign load_ok  = load_enable && ((state_q == StIdle) || last_bit);

    // State register
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_ok) begin
                    state_d = StSend;
                end else if (eop) begin
                    state_d = StEop1;
                end
            end
            StSend: begin
                if (last_bit) begin
                    if (load_ok) begin
                        state_d = StSend;
                    end else if (pend_q || eop) begin
                        state_d = StEop1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StEop1:  state_d = StEop2;
            StEop2:  state_d = StEopJ;
            StEopJ:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shift register, bit counter and pending end-of-packet
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (state_q == StSend) begin
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 3'd1;
        end
        if (load_ok) begin
            shift_d = data;
            cnt_d   = 3'd0;
        end
        // An eop that cannot start at once (byte in flight, or load winning in idle) waits.
        if (eop && ((state_q == StSend) || ((state_q == StIdle) && load_ok))) begin
            pend_d = 1'b1;
        end
        if (state_d == StEop1) begin
            pend_d = 1'b0;
        end
    end

    // Output logic: next values of the registered line and busy flag
    always_comb begin
        level_d = level_q;
        dp_d    = level_q;
        dm_d    = ~level_q;
        busy_d  = (state_d != StIdle) || (state_q != StIdle);
        unique case (state_q)
            StSend: begin
                level_d = shift_q[0] ? level_q : ~level_q;
                dp_d    = level_d;
                dm_d    = ~level_d;
            end
            StEop1, StEop2: begin
                dp_d = 1'b0;
                dm_d = 1'b0;
            end
            StEopJ: begin
                level_d = 1'b1;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            level_q <= 1'b1;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            level_q <= level_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            busy_q  <= busy_d;
        end
    end

    assign d_plus  = dp_q;
    assign d_minus = dm_q;
    assign busy    = busy_q;

    a_no_se1: assert property (@(posedge clk) disable iff (n_rst) !(d_plus && d_minus));

endmodule

// File: tb/tb_usb_transmitter.sv
// Bench for usb_transmitter: table of bytes with hand-derived NRZI levels plus corner sequences,
// checked through a cycle-stamped scoreboard queue.
module tb_usb_transmitter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       load_enable;
    logic [7:0] data;
    logic       eop;
    logic       d_plus;
    logic       d_minus;
    logic       busy;

    usb_transmitter dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_enable(load_enable),
        .data       (data),
        .eop        (eop),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic dp;
        logic dm;
        logic bz;
    } exp_t;

    // levels[i] is the line level (1 = J) after bit i
    typedef struct {
        logic [7:0] data;
        logic [7:0] levels;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_k = 0;
    logic lvl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int c, input logic [2:0] act,
                         input logic [2:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got dp/dm/busy=%b expected %b", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (n_rst === 1'b0) begin
            check("line_legal", cyc, {2'b00, d_plus & d_minus}, 3'b000);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("line", e.cyc, {d_plus, d_minus, busy}, {e.dp, e.dm, e.bz});
            end
        end
    end

    task automatic push(input int c, input logic dp, input logic dm, input logic bz);
        exp_t e;
        if (sb.size() > 0 && sb[$].cyc >= c) return;
        e.cyc = c;
        e.dp  = dp;
        e.dm  = dm;
        e.bz  = bz;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            push(cyc + 1, lvl, !lvl, 1'b0);
            step();
        end
    endtask

    // First SE0 at cycle c: SE0, SE0, J (busy), then idle J
    task automatic push_eop(input int c);
        push(c, 1'b0, 1'b0, 1'b1);
        push(c + 1, 1'b0, 1'b0, 1'b1);
        push(c + 2, 1'b1, 1'b0, 1'b1);
        push(c + 3, 1'b1, 1'b0, 1'b0);
        lvl = 1'b1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic [7:0] lv, input logic with_eop);
        int k;
        k           = cyc + 1;
        data        = d;
        load_enable = 1'b1;
        eop         = with_eop;
        push(k, lvl, !lvl, 1'b1);
        for (int i = 0; i < 8; i++) push(k + 1 + i, lv[i], !lv[i], 1'b1);
        lvl    = lv[7];
        last_k = k;
        step();
        load_enable = 1'b0;
        eop         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h00, 8'hAA};  // from J
        vecs[1] = '{8'hA5, 8'hC9};  // from J
        vecs[2] = '{8'h80, 8'h2A};  // from J, ends K
        vecs[3] = '{8'h55, 8'h66};  // from K
        vecs[4] = '{8'h0F, 8'h50};  // from K
        vecs[5] = '{8'hFF, 8'h00};  // from K
        vecs[6] = '{8'h01, 8'hAA};  // from K, ends J

        n_rst       = 1'b1;
        load_enable = 1'b0;
        eop         = 1'b0;
        data        = 8'h00;
        lvl         = 1'b1;
        #2;
        check("reset_state", cyc, {d_plus, d_minus, busy}, 3'b100);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        idle(5);

        foreach (vecs[i]) begin
            load_byte(vecs[i].data, vecs[i].levels, 1'b0);
            wait_cycles(8);
            idle(3);
        end

        // 9-cycle cadence: 0xFF then 0x80 from J
        load_byte(8'hFF, 8'hFF, 1'b0);
        wait_cycles(8);
        load_byte(8'h80, 8'h2A, 1'b0);
        wait_cycles(8);
        idle(3);

        // Back-to-back from K: 0x01, then 0x02 on the bit-7 cycle
        load_byte(8'h01, 8'hAA, 1'b0);
        wait_cycles(7);
        load_byte(8'h02, 8'h54, 1'b0);
        wait_cycles(8);
        idle(3);

        // eop mid-byte, 0xA5 from K
        load_byte(8'hA5, 8'h36, 1'b0);
        wait_cycles(2);
        eop = 1'b1;
        step();
        eop = 1'b0;
        push_eop(last_k + 9);
        wait_cycles(9);
        idle(2);

        // eop together with load in idle: byte first, then EOP
        load_byte(8'h03, 8'hAB, 1'b1);
        push_eop(last_k + 9);
        wait_cycles(12);
        idle(2);

        // eop from idle, with a load during EOP1 that must be ignored
        push(cyc + 1, lvl, !lvl, 1'b1);
        push_eop(cyc + 2);
        eop = 1'b1;
        step();
        eop         = 1'b0;
        data        = 8'h00;
        load_enable = 1'b1;
        step();
        load_enable = 1'b0;
        wait_cycles(3);
        idle(2);

        // Asynchronous reset while bit 3 of 0x08 (line at K) is on the line
        load_byte(8'h08, 8'h52, 1'b0);
        wait_cycles(4);
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        check("async_reset", cyc, {d_plus, d_minus, busy}, 3'b100);
        sb.delete();
        lvl = 1'b1;
        step();
        step();
        n_rst = 1'b0;
        idle(2);
        load_byte(8'h00, 8'hAA, 1'b0);
        wait_cycles(8);
        idle(3);

        wait_cycles(3);
        check("sb_drain", cyc, {2'b00, sb.size() != 0}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
